// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI mode-3 responder.
package spi_resp_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int   RW_BIT   = 7;
  localparam int   MB_BIT   = 6;
  localparam logic IDLE_SDO = 1'b1;

endpackage

// File: rtl/spi_resp_sync.sv
// N-stage synchronizer with a selectable reset level.
module spi_resp_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= {N{RST_VAL}};
    else        chain <= {chain[N-2:0], d};
  end

  assign q = chain[N-1];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-3 responder with an internal register file and a host-side port.
// Optional SPI write protection of RO_MASK registers: define SPI_RESP_WPROT_EN.
module spi_responder
  import spi_resp_pkg::*;
#(
  parameter int          ADDR_W      = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [63:0] RO_MASK     = 64'h0
) (
  input  logic              spi_clk,
  input  logic              reset_n,
  input  logic              SPI_CLK,
  input  logic              SPI_CSN,
  input  logic              SPI_SDI,
  output logic              SPI_SDO,
  output logic              SPI_SDO_OE,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output state_t            dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef SPI_RESP_WPROT_EN
  localparam logic WPROT_ON = 1'b1;
`else
  localparam logic WPROT_ON = 1'b0;
`endif

  logic sclk_s, csn_s, sdi_s;
  logic sclk_d, csn_d;

  spi_resp_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
    .clk(spi_clk), .rst_n(reset_n), .d(SPI_CLK), .q(sclk_s)
  );
  spi_resp_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(spi_clk), .rst_n(reset_n), .d(SPI_CSN), .q(csn_s)
  );
  spi_resp_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(spi_clk), .rst_n(reset_n), .d(SPI_SDI), .q(sdi_s)
  );

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_d <= 1'b1;
      csn_d  <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      csn_d  <= csn_s;
    end
  end

  logic rise, fall, csn_fall, csn_rise;
  assign rise     = sclk_s & ~sclk_d;
  assign fall     = ~sclk_s & sclk_d;
  assign csn_fall = ~csn_s & csn_d;
  assign csn_rise = csn_s & ~csn_d;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              mb;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        mem [DEPTH];

  logic [7:0] next_byte;
  logic       byte_end, abort, writable, spi_commit;

  assign next_byte  = {shift[6:0], sdi_s};
  assign byte_end   = rise && (bit_cnt == 3'd7);
  assign abort      = csn_s && (state != IDLE);
  assign writable   = ~(WPROT_ON & RO_MASK[addr]);
  // A frame ending on the same cycle as the 8th rise never commits.
  assign spi_commit = (state == WR) && !abort && byte_end && writable;

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      mb         <= 1'b0;
      addr       <= '0;
      SPI_SDO    <= IDLE_SDO;
      SPI_SDO_OE <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      wr_strobe  <= 1'b0;
      frame_done <= csn_rise;
      if (abort) begin
        state      <= IDLE;
        SPI_SDO    <= IDLE_SDO;
        SPI_SDO_OE <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            SPI_SDO    <= IDLE_SDO;
            SPI_SDO_OE <= 1'b0;
            if (csn_fall) begin
              bit_cnt <= 3'd0;
              state   <= CMD;
            end
          end
          CMD: begin
            if (rise) begin
              shift   <= next_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                mb    <= next_byte[MB_BIT];
                addr  <= next_byte[ADDR_W-1:0];
                state <= next_byte[RW_BIT] ? RD : WR;
              end
            end
          end
          RD: begin
            if (fall) begin
              SPI_SDO_OE <= 1'b1;
              // Byte start samples the register as it stands this cycle.
              if (bit_cnt == 3'd0) begin
                SPI_SDO <= mem[addr][7];
                shift   <= {mem[addr][6:0], 1'b0};
              end else begin
                SPI_SDO <= shift[7];
                shift   <= {shift[6:0], 1'b0};
              end
            end
            if (rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (mb) addr  <= addr + 1'b1;
                else    state <= DONE;
              end
            end
          end
          WR: begin
            if (rise) begin
              shift   <= next_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (spi_commit) begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr;
                  wr_data   <= next_byte;
                end
                if (mb) addr  <= addr + 1'b1;
                else    state <= DONE;
              end
            end
          end
          DONE: begin
            SPI_SDO    <= IDLE_SDO;
            SPI_SDO_OE <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // SPI commit is scheduled after the host write so it wins on a collision.
  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (host_we)    mem[host_addr] <= host_wdata;
      if (spi_commit) mem[addr]      <= next_byte;
    end
  end

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) host_rdata <= 8'h00;
    else          host_rdata <= mem[host_addr];
  end

  assign busy      = ~csn_s;
  assign dbg_state = state;

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: directed scenarios plus random frames
// checked against a byte-level frame model.
module tb_spi_responder;
  import spi_resp_pkg::*;

  localparam int HALF = 8;

`ifdef SPI_RESP_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic       spi_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       SPI_CLK = 1'b1;
  logic       SPI_CSN = 1'b1;
  logic       SPI_SDI = 1'b0;
  logic       SPI_SDO, SPI_SDO_OE;
  logic [5:0] host_addr = '0;
  logic       host_we = 1'b0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, frame_done;
  state_t     dbg_state;

  always #5 spi_clk = ~spi_clk;

  spi_responder #(.ADDR_W(6), .SYNC_STAGES(2), .RO_MASK(64'h1)) dut (
    .spi_clk(spi_clk), .reset_n(reset_n),
    .SPI_CLK(SPI_CLK), .SPI_CSN(SPI_CSN), .SPI_SDI(SPI_SDI),
    .SPI_SDO(SPI_SDO), .SPI_SDO_OE(SPI_SDO_OE),
    .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  model_mem [64];
  logic [7:0]  tx [8];
  logic [7:0]  rx [8];
  logic [7:0]  exp_rx [8];
  logic [13:0] exp_q [$];
  logic [13:0] obs_q [$];
  int          fd_cnt = 0;

  always @(negedge spi_clk) begin
    if (reset_n) begin
      if (wr_strobe)  obs_q.push_back({wr_addr, wr_data});
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge spi_clk);
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge spi_clk);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge spi_clk);
    host_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic host_read(input logic [5:0] a, output logic [7:0] d);
    @(negedge spi_clk);
    host_addr = a;
    @(negedge spi_clk);
    d = host_rdata;
  endtask

  // Sends tx[0..n-1]; stops after stop_bits bits if >= 0. While the bit
  // numbered hook_bit is being sampled, host_we straddles the commit cycle.
  task automatic spi_xfer(input int n, input int stop_bits, input int hook_bit);
    int bits;
    bit stopped;
    bits = 0; stopped = 1'b0;
    @(negedge spi_clk);
    SPI_CSN = 1'b0;
    idle(HALF);
    for (int b = 0; b < n; b++) begin
      for (int i = 7; i >= 0; i--) begin
        if (!stopped) begin
          SPI_CLK = 1'b0; SPI_SDI = tx[b][i];
          idle(HALF);
          rx[b][i] = SPI_SDO;
          SPI_CLK = 1'b1;
          for (int c = 1; c <= HALF; c++) begin
            @(negedge spi_clk);
            if (bits == hook_bit && c == 1) host_we = 1'b1;
            if (bits == hook_bit && c == 3) host_we = 1'b0;
          end
          bits++;
          if (bits == stop_bits) stopped = 1'b1;
        end
      end
    end
    idle(HALF);
    SPI_CSN = 1'b1;
    idle(12);
  endtask

  // Frame model over whole bytes: n_done counts fully transferred bytes.
  task automatic model_frame(input int n_done);
    logic [5:0] a;
    bit rd, mbit;
    a = tx[0][5:0]; rd = tx[0][7]; mbit = tx[0][6];
    for (int k = 0; k < 8; k++) exp_rx[k] = 8'hFF;
    for (int k = 1; k < n_done; k++) begin
      if (k > 1 && !mbit) break;
      if (rd) exp_rx[k] = model_mem[a];
      else if (!(WPROT && a == 6'd0)) begin
        model_mem[a] = tx[k];
        exp_q.push_back({a, tx[k]});
      end
      a = a + 6'd1;
    end
  endtask

  task automatic cmp_writes(output bit ok, output int n_obs, output int n_exp);
    n_obs = obs_q.size(); n_exp = exp_q.size();
    ok = (n_obs == n_exp);
    if (ok) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) ok = 1'b0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; host_we = 1'b0;
    SPI_CSN = 1'b1; SPI_CLK = 1'b1;
    idle(4);
    reset_n = 1'b1;
    idle(4);
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
    obs_q.delete(); exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] d;
    n_tests++;
    if (SPI_SDO !== 1'b1 || SPI_SDO_OE !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pins: sdo=%b oe=%b busy=%b, want 1 0 0", SPI_SDO, SPI_SDO_OE, busy);
    end
    n_tests++;
    if (wr_strobe !== 1'b0 || frame_done !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_ctrl: strobe=%b done=%b state=%0d, want 0 0 IDLE",
               wr_strobe, frame_done, dbg_state);
    end
    host_read(6'h3F, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++; $display("FAIL reset_reg: reg 0x3f=%h, want 00", d);
    end
  endtask

  task automatic test_read();
    int fd0, no, ne; bit ok;
    host_write(6'h32, 8'hA5);
    tx[0] = 8'hB2; tx[1] = 8'h00;
    model_frame(2);
    fd0 = fd_cnt;
    spi_xfer(2, -1, -1);
    n_tests++;
    if (rx[1] !== 8'hA5) begin
      n_fail++; $display("FAIL read_data: got %h, want a5", rx[1]);
    end
    n_tests++;
    if (fd_cnt - fd0 != 1) begin
      n_fail++; $display("FAIL read_frame_done: %0d pulses, want 1", fd_cnt - fd0);
    end
    cmp_writes(ok, no, ne);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL read_no_write: %0d writes, want %0d", no, ne);
    end
    n_tests++;
    if (SPI_SDO_OE !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL read_idle: oe=%b busy=%b, want 0 0", SPI_SDO_OE, busy);
    end
  endtask

  task automatic test_write();
    int no, ne; bit ok; logic [7:0] d;
    tx[0] = 8'h2D; tx[1] = 8'h08;
    model_frame(2);
    spi_xfer(2, -1, -1);
    cmp_writes(ok, no, ne);
    n_tests++;
    if (!ok || no != 1) begin
      n_fail++; $display("FAIL write_strobe: %0d writes (match=%b), want 1 at 2d=08", no, ok);
    end
    host_read(6'h2D, d);
    n_tests++;
    if (d !== 8'h08) begin
      n_fail++; $display("FAIL write_reg: reg 0x2d=%h, want 08", d);
    end
  endtask

  task automatic test_multibyte();
    int no, ne; bit ok; logic [7:0] d;
    host_write(6'h32, 8'h11); host_write(6'h33, 8'h22); host_write(6'h34, 8'h33);
    tx[0] = 8'hF2; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h00;
    model_frame(4);
    spi_xfer(4, -1, -1);
    n_tests++;
    if (rx[1] !== exp_rx[1] || rx[2] !== exp_rx[2] || rx[3] !== exp_rx[3]) begin
      n_fail++;
      $display("FAIL mb_read: got %h %h %h, want %h %h %h",
               rx[1], rx[2], rx[3], exp_rx[1], exp_rx[2], exp_rx[3]);
    end
    tx[0] = 8'h7F; tx[1] = 8'hC4; tx[2] = 8'h5B;
    model_frame(3);
    spi_xfer(3, -1, -1);
    cmp_writes(ok, no, ne);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL mb_write_wrap: %0d writes, want %0d in order", no, ne);
    end
    host_read(6'h3F, d);
    n_tests++;
    if (d !== model_mem[6'h3F]) begin
      n_fail++; $display("FAIL mb_reg3f: got %h, want %h", d, model_mem[6'h3F]);
    end
  endtask

  task automatic test_abort();
    int no, ne, fd0; bit ok; logic [7:0] d;
    tx[0] = 8'h20; tx[1] = 8'hFF;
    model_frame(1);
    fd0 = fd_cnt;
    spi_xfer(2, 12, -1);
    cmp_writes(ok, no, ne);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL abort_no_write: %0d writes, want %0d", no, ne);
    end
    n_tests++;
    if (fd_cnt - fd0 != 1) begin
      n_fail++; $display("FAIL abort_frame_done: %0d pulses, want 1", fd_cnt - fd0);
    end
    host_read(6'h20, d);
    n_tests++;
    if (d !== model_mem[6'h20]) begin
      n_fail++; $display("FAIL abort_reg: got %h, want %h", d, model_mem[6'h20]);
    end
    tx[0] = 8'h20; tx[1] = 8'h3C;
    model_frame(2);
    spi_xfer(2, -1, -1);
    cmp_writes(ok, no, ne);
    host_read(6'h20, d);
    n_tests++;
    if (!ok || d !== 8'h3C) begin
      n_fail++; $display("FAIL abort_recover: reg=%h writes=%0d, want 3c and %0d", d, no, ne);
    end
  endtask

  task automatic test_collision();
    int no, ne; bit ok; logic [7:0] d;
    host_addr = 6'h10; host_wdata = 8'h55;
    model_mem[6'h10] = 8'h55;
    tx[0] = 8'h10; tx[1] = 8'hAA;
    model_frame(2);
    spi_xfer(2, -1, 15);
    cmp_writes(ok, no, ne);
    host_read(6'h10, d);
    n_tests++;
    if (d !== 8'hAA || !ok) begin
      n_fail++; $display("FAIL collide_same: reg 0x10=%h writes=%0d, want aa and %0d", d, no, ne);
    end
    host_addr = 6'h13; host_wdata = 8'h66;
    model_mem[6'h13] = 8'h66;
    tx[0] = 8'h12; tx[1] = 8'h99;
    model_frame(2);
    spi_xfer(2, -1, 15);
    cmp_writes(ok, no, ne);
    host_read(6'h12, d);
    n_tests++;
    if (d !== 8'h99 || !ok) begin
      n_fail++; $display("FAIL collide_diff_spi: reg 0x12=%h, want 99", d);
    end
    host_read(6'h13, d);
    n_tests++;
    if (d !== 8'h66) begin
      n_fail++; $display("FAIL collide_diff_host: reg 0x13=%h, want 66", d);
    end
  endtask

  task automatic test_wprot();
    int no, ne; bit ok; logic [7:0] d;
    tx[0] = 8'h00; tx[1] = 8'h77;
    model_frame(2);
    spi_xfer(2, -1, -1);
    cmp_writes(ok, no, ne);
    host_read(6'h00, d);
    n_tests++;
    if (!ok || d !== model_mem[6'h00]) begin
      n_fail++;
      $display("FAIL wprot_reg0: reg=%h writes=%0d, want %h and %0d", d, no, model_mem[6'h00], ne);
    end
    tx[0] = 8'h01; tx[1] = 8'h77;
    model_frame(2);
    spi_xfer(2, -1, -1);
    cmp_writes(ok, no, ne);
    host_read(6'h01, d);
    n_tests++;
    if (!ok || d !== 8'h77) begin
      n_fail++; $display("FAIL wprot_reg1: reg=%h writes=%0d, want 77 and %0d", d, no, ne);
    end
  endtask

  task automatic test_random();
    int n, stop, n_done, fd0, no, ne; bit ok, rx_ok;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1)
        host_write(6'($urandom_range(0, 63)), 8'($urandom));
      n = $urandom_range(1, 5);
      for (int k = 0; k < 8; k++) tx[k] = 8'($urandom);
      stop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n * 8 - 1) : -1;
      n_done = (stop < 0) ? n : stop / 8;
      model_frame(n_done);
      fd0 = fd_cnt;
      spi_xfer(n, stop, -1);
      rx_ok = 1'b1;
      if (tx[0][7])
        for (int k = 1; k < n_done; k++) if (rx[k] !== exp_rx[k]) rx_ok = 1'b0;
      cmp_writes(ok, no, ne);
      n_tests++;
      if (!rx_ok || !ok || fd_cnt - fd0 != 1) begin
        n_fail++;
        $display("FAIL random_%0d: cmd=%h n=%0d stop=%0d rx_ok=%b writes=%0d/%0d done=%0d",
                 it, tx[0], n, stop, rx_ok, no, ne, fd_cnt - fd0);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int nonzero;
    host_write(6'h05, 8'h5A);
    tx[0] = 8'hB2; tx[1] = 8'h00;
    @(negedge spi_clk);
    SPI_CSN = 1'b0;
    idle(HALF);
    for (int b = 0; b < 11; b++) begin
      SPI_CLK = 1'b0; SPI_SDI = (b < 8) ? tx[0][7 - b] : 1'b0;
      idle(HALF);
      SPI_CLK = 1'b1;
      idle(HALF);
    end
    n_tests++;
    if (SPI_SDO_OE !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_read_active: oe=%b busy=%b, want 1 1", SPI_SDO_OE, busy);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (SPI_SDO !== 1'b1 || SPI_SDO_OE !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_pins: sdo=%b oe=%b busy=%b, want 1 0 0", SPI_SDO, SPI_SDO_OE, busy);
    end
    SPI_CSN = 1'b1; SPI_CLK = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(3);
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
    nonzero = 0;
    for (int i = 0; i < 64; i++) begin
      host_read(6'(i), d);
      if (d !== 8'h00) nonzero++;
    end
    n_tests++;
    if (nonzero != 0) begin
      n_fail++; $display("FAIL mid_reset_clear: %0d registers nonzero, want 0", nonzero);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_read();
    test_write();
    test_multibyte();
    test_abort();
    test_collision();
    test_wprot();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
